// File: rtl/calc_pkg.sv
// Shared opcodes, sequencer states, error-bit positions and settle-latency
// selection for the accumulator calculator command sequencer.
package calc_pkg;

  localparam logic [3:0] OP_NOP    = 4'b0000;
  localparam logic [3:0] OP_ADD    = 4'b0010;
  localparam logic [3:0] OP_SUB    = 4'b0011;
  localparam logic [3:0] OP_MUL    = 4'b0100;
  localparam logic [3:0] OP_DIV    = 4'b0101;
  localparam logic [3:0] OP_MOD    = 4'b0110;
  localparam logic [3:0] OP_PRESET = 4'b1110;
  localparam logic [3:0] OP_RESET  = 4'b1111;

  localparam int ERR_OVF     = 0;
  localparam int ERR_DZERO   = 1;
  localparam int ERR_ILLEGAL = 2;

  localparam int LAT_W = 8;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_SETTLE,
    ST_COMMIT,
    ST_REPORT,
    ST_HALT
  } state_t;

  function automatic logic is_legal(input logic [3:0] op);
    logic ok;
    case (op)
      OP_NOP, OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_MOD, OP_PRESET, OP_RESET: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [LAT_W-1:0] lat_sel(input logic [3:0] op, input int mul_lat,
                                              input int div_lat);
    logic [LAT_W-1:0] lat;
    case (op)
      OP_MUL:         lat = LAT_W'(mul_lat);
      OP_DIV, OP_MOD: lat = LAT_W'(div_lat);
      default:        lat = '0;
    endcase
    return lat;
  endfunction

endpackage

// File: rtl/calc_cmd_fifo.sv
// DEPTH-entry synchronous command FIFO with full/empty flags; reset flushes
// the pointers only, stored words are simply abandoned.
module calc_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 20
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push_en;
  logic             pop_en;

  assign full     = (count_q == (AW + 1)'(DEPTH));
  assign empty    = (count_q == '0);
  assign push_en  = push && !full;
  assign pop_en   = pop && !empty;
  assign pop_data = mem_q[rd_ptr_q];

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_en)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push_en && !pop_en)      count_d = count_q + 1'b1;
    else if (pop_en && !push_en) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/calc_sequencer.sv
// Feeds buffered host commands to the accumulator datapath one at a time,
// holding it with no-ops while slow units settle, and reports each result.
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int MUL_LAT = 2,
  parameter int DIV_LAT = 1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CMD_VALID,
  output logic        CMD_READY,
  input  logic [3:0]  CMD_OP,
  input  logic [15:0] CMD_DATA,
  output logic [3:0]  DP_OP,
  output logic [15:0] DP_IN,
  input  logic [31:0] DP_OUT,
  input  logic [1:0]  DP_ERR,
  output logic        RES_VALID,
  output logic [31:0] RES_DATA,
  output logic [2:0]  RES_ERR,
  output logic [2:0]  STICKY_ERR,
  input  logic        CLR_ERR,
  input  logic        HALT_ON_ERR,
  output logic        BUSY
);

  state_t           state_q, state_d;
  logic [3:0]       cmd_op_q, cmd_op_d;
  logic [15:0]      dp_in_q, dp_in_d;
  logic [LAT_W-1:0] lat_cnt_q, lat_cnt_d;
  logic [2:0]       err_q, err_d;
  logic [2:0]       sticky_q, sticky_d;
  logic [31:0]      res_data_q, res_data_d;

  logic             fifo_push;
  logic             fifo_pop;
  logic [19:0]      fifo_rdata;
  logic             fifo_full;
  logic             fifo_empty;
  logic [3:0]       pop_op;
  logic [LAT_W-1:0] pop_lat;

  assign CMD_READY  = !fifo_full && (state_q != ST_INIT);
  assign fifo_push  = CMD_VALID && CMD_READY;
  assign pop_op     = fifo_rdata[19:16];
  assign pop_lat    = lat_sel(pop_op, MUL_LAT, DIV_LAT);
  assign DP_IN      = dp_in_q;
  assign RES_ERR    = err_q;
  assign STICKY_ERR = sticky_q;
  assign BUSY       = (state_q != ST_IDLE) || !fifo_empty;
  assign RES_DATA   = (state_q == ST_REPORT) ? DP_OUT : res_data_q;

  calc_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (20)
  ) u_fifo (
    .clk       (CLK),
    .srst      (RST),
    .push      (fifo_push),
    .push_data ({CMD_OP, CMD_DATA}),
    .pop       (fifo_pop),
    .pop_data  (fifo_rdata),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    state_d    = state_q;
    cmd_op_d   = cmd_op_q;
    dp_in_d    = dp_in_q;
    lat_cnt_d  = lat_cnt_q;
    err_d      = err_q;
    sticky_d   = sticky_q;
    res_data_d = res_data_q;
    DP_OP      = OP_NOP;
    RES_VALID  = 1'b0;
    fifo_pop   = 1'b0;

    case (state_q)
      ST_INIT: begin
        DP_OP   = OP_RESET;
        state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          cmd_op_d = pop_op;
          // Illegal opcodes never reach the datapath, so DP_IN is left alone.
          if (!is_legal(pop_op)) begin
            err_d   = 3'b100;
            state_d = ST_REPORT;
          end else begin
            dp_in_d   = fifo_rdata[15:0];
            lat_cnt_d = pop_lat;
            state_d   = (pop_lat == '0) ? ST_COMMIT : ST_SETTLE;
          end
        end
      end
      ST_SETTLE: begin
        lat_cnt_d = lat_cnt_q - 1'b1;
        if (lat_cnt_q <= 1) state_d = ST_COMMIT;
      end
      ST_COMMIT: begin
        DP_OP               = cmd_op_q;
        err_d               = '0;
        err_d[ERR_OVF]      = ((cmd_op_q == OP_ADD) || (cmd_op_q == OP_SUB)) && DP_ERR[0];
        err_d[ERR_DZERO]    = ((cmd_op_q == OP_DIV) || (cmd_op_q == OP_MOD)) && DP_ERR[1];
        state_d             = ST_REPORT;
      end
      ST_REPORT: begin
        RES_VALID  = 1'b1;
        res_data_d = DP_OUT;
        sticky_d   = sticky_q | err_q;
        state_d    = (HALT_ON_ERR && (err_q != '0)) ? ST_HALT : ST_IDLE;
      end
      ST_HALT: begin
        if (CLR_ERR) state_d = ST_IDLE;
      end
      default: state_d = ST_INIT;
    endcase

    // A clear arriving with a report keeps the fresh error.
    if (CLR_ERR) sticky_d = (state_q == ST_REPORT) ? err_q : 3'b000;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= ST_INIT;
      cmd_op_q   <= OP_NOP;
      dp_in_q    <= '0;
      lat_cnt_q  <= '0;
      err_q      <= '0;
      sticky_q   <= '0;
      res_data_q <= '0;
    end else begin
      state_q    <= state_d;
      cmd_op_q   <= cmd_op_d;
      dp_in_q    <= dp_in_d;
      lat_cnt_q  <= lat_cnt_d;
      err_q      <= err_d;
      sticky_q   <= sticky_d;
      res_data_q <= res_data_d;
    end
  end

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed and randomized bench for calc_sequencer with an emulated
// accumulator datapath and a command-level reference model.
module tb_calc_sequencer;

  logic        CLK = 1'b0;
  logic        RST;
  logic        CMD_VALID;
  logic        CMD_READY;
  logic [3:0]  CMD_OP;
  logic [15:0] CMD_DATA;
  logic [3:0]  DP_OP;
  logic [15:0] DP_IN;
  logic [31:0] DP_OUT;
  logic [1:0]  DP_ERR;
  logic        RES_VALID;
  logic [31:0] RES_DATA;
  logic [2:0]  RES_ERR;
  logic [2:0]  STICKY_ERR;
  logic        CLR_ERR;
  logic        HALT_ON_ERR;
  logic        BUSY;

  always #5 CLK = ~CLK;

  calc_sequencer #(.DEPTH(4), .MUL_LAT(2), .DIV_LAT(1)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .CMD_VALID   (CMD_VALID),
    .CMD_READY   (CMD_READY),
    .CMD_OP      (CMD_OP),
    .CMD_DATA    (CMD_DATA),
    .DP_OP       (DP_OP),
    .DP_IN       (DP_IN),
    .DP_OUT      (DP_OUT),
    .DP_ERR      (DP_ERR),
    .RES_VALID   (RES_VALID),
    .RES_DATA    (RES_DATA),
    .RES_ERR     (RES_ERR),
    .STICKY_ERR  (STICKY_ERR),
    .CLR_ERR     (CLR_ERR),
    .HALT_ON_ERR (HALT_ON_ERR),
    .BUSY        (BUSY)
  );

  // Emulated datapath: acts on DP_OP at every edge, flags are combinational
  // and can be polluted with noise to exercise the sequencer's masking.
  logic [31:0] acc_dp = 32'hDEAD_BEEF;
  logic [1:0]  err_noise = 2'b00;
  logic        dp_ovf;
  logic        dp_dz;

  assign DP_OUT = acc_dp;
  assign DP_ERR = {dp_dz | err_noise[1], dp_ovf | err_noise[0]};

  always @(posedge CLK) begin
    case (DP_OP)
      4'b1111: acc_dp <= 32'h0;
      4'b0010: acc_dp <= acc_dp + {16'h0, DP_IN};
      4'b0011: acc_dp <= acc_dp - {16'h0, DP_IN};
      4'b0100: acc_dp <= acc_dp * {16'h0, DP_IN};
      4'b0101: if (DP_IN != 16'h0) acc_dp <= acc_dp / {16'h0, DP_IN};
      4'b0110: if (DP_IN != 16'h0) acc_dp <= acc_dp % {16'h0, DP_IN};
      4'b1110: acc_dp <= {16'h0, DP_IN};
      default: ;
    endcase
  end

  always_comb begin
    dp_ovf = 1'b0;
    dp_dz  = 1'b0;
    case (DP_OP)
      4'b0010: dp_ovf = (64'(acc_dp) + 64'(DP_IN)) > 64'hFFFF_FFFF;
      4'b0011: dp_ovf = {16'h0, DP_IN} > acc_dp;
      4'b0100: dp_ovf = (64'(acc_dp) * 64'(DP_IN)) > 64'hFFFF_FFFF;
      4'b0101, 4'b0110: dp_dz = (DP_IN == 16'h0);
      default: ;
    endcase
  end

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] m_acc = 32'h0;
  logic [2:0]  m_sticky = 3'b000;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit op_legal(input logic [3:0] op);
    return (op == 4'd0) || (op >= 4'd2 && op <= 4'd6) || (op >= 4'd14);
  endfunction

  // Reference model: what one command does to the accumulator and which
  // error bits the host should see for it.
  task automatic model_cmd(input logic [3:0] op, input logic [15:0] d, input logic [1:0] noise,
                           output logic [31:0] res, output logic [2:0] err);
    err = 3'b000;
    case (op)
      4'd0: ;
      4'd2: begin
        err[0] = ((64'(m_acc) + 64'(d)) > 64'hFFFF_FFFF) || noise[0];
        m_acc  = m_acc + 32'(d);
      end
      4'd3: begin
        err[0] = (32'(d) > m_acc) || noise[0];
        m_acc  = m_acc - 32'(d);
      end
      4'd4: m_acc = m_acc * 32'(d);
      4'd5, 4'd6: begin
        err[1] = (d == 16'h0) || noise[1];
        if (d != 16'h0) m_acc = (op == 4'd5) ? m_acc / 32'(d) : m_acc % 32'(d);
      end
      4'd14: m_acc = 32'(d);
      4'd15: m_acc = 32'h0;
      default: err[2] = 1'b1;
    endcase
    res = m_acc;
  endtask

  // Starts on a negedge where the sequencer is IDLE (about to pop), waits
  // for the report and checks latency, datapath sequence, result and errors.
  task automatic wait_result(input logic [3:0] op, input logic [15:0] d, input logic [1:0] noise,
                             input bit clr, input bit more);
    logic [31:0] exp_res;
    logic [2:0]  exp_err;
    int          k;
    int          lat;
    int          exp_k;
    bit          seq_ok;
    bit          legal;
    err_noise = noise;
    model_cmd(op, d, noise, exp_res, exp_err);
    legal  = !exp_err[2];
    lat    = (op == 4'd4) ? 2 : ((op == 4'd5 || op == 4'd6) ? 1 : 0);
    exp_k  = legal ? 2 + lat : 1;
    k      = 0;
    seq_ok = 1'b1;
    while (RES_VALID !== 1'b1 && k < 40) begin
      if (!op_legal(DP_OP)) seq_ok = 1'b0;
      if (legal && k >= 1 && k <= lat && (DP_OP !== 4'd0 || DP_IN !== d)) seq_ok = 1'b0;
      if (legal && k == lat + 1 && (DP_OP !== op || DP_IN !== d)) seq_ok = 1'b0;
      @(negedge CLK);
      k++;
    end
    chk("latency", 32'(k), 32'(exp_k));
    chk("dp_seq", {31'h0, seq_ok}, 32'h1);
    chk("res_data", RES_DATA, exp_res);
    chk("res_err", {29'h0, RES_ERR}, {29'h0, exp_err});
    if (clr) m_sticky = exp_err;
    else     m_sticky = m_sticky | exp_err;
    CLR_ERR = clr;
    @(negedge CLK);
    CLR_ERR = 1'b0;
    chk("sticky", {29'h0, STICKY_ERR}, {29'h0, m_sticky});
    chk("busy_after", {31'h0, BUSY}, {31'h0, more || (HALT_ON_ERR && exp_err != 3'b000)});
    $display("cmd op=%b data=%h res=%h err=%b sticky=%b", op, d, RES_DATA, exp_err, m_sticky);
  endtask

  task automatic do_cmd(input logic [3:0] op, input logic [15:0] d, input logic [1:0] noise,
                        input bit clr);
    @(negedge CLK);
    CMD_VALID = 1'b1;
    CMD_OP    = op;
    CMD_DATA  = d;
    chk("cmd_ready", {31'h0, CMD_READY}, 32'h1);
    @(negedge CLK);
    CMD_VALID = 1'b0;
    wait_result(op, d, noise, clr, 1'b0);
  endtask

  logic [3:0]  op_tab [12] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd9, 4'd12,
                                4'd14, 4'd15};
  logic [3:0]  q_op [5] = '{4'd14, 4'd2, 4'd4, 4'd3, 4'd2};
  logic [15:0] q_d  [5] = '{16'h1234, 16'h0002, 16'h0003, 16'h0001, 16'h7777};

  initial begin
    int          idx;
    int          seen;
    logic [3:0]  r_op;
    logic [15:0] r_d;

    RST = 1'b1; CMD_VALID = 1'b0; CMD_OP = 4'd0; CMD_DATA = 16'h0;
    CLR_ERR = 1'b0; HALT_ON_ERR = 1'b0;
    repeat (3) @(negedge CLK);
    chk("rst_res_valid", {31'h0, RES_VALID}, 32'h0);
    chk("rst_res_data", RES_DATA, 32'h0);
    chk("rst_res_err", {29'h0, RES_ERR}, 32'h0);
    chk("rst_sticky", {29'h0, STICKY_ERR}, 32'h0);
    chk("rst_dp_op", {28'h0, DP_OP}, 32'hF);
    chk("rst_dp_in", {16'h0, DP_IN}, 32'h0);
    chk("rst_ready", {31'h0, CMD_READY}, 32'h0);

    // Release: one more INIT cycle driving 1111, then IDLE.
    RST = 1'b0;
    chk("init_dp_op", {28'h0, DP_OP}, 32'hF);
    @(negedge CLK);
    chk("idle_dp_op", {28'h0, DP_OP}, 32'h0);
    chk("idle_dp_out", DP_OUT, 32'h0);
    chk("idle_busy", {31'h0, BUSY}, 32'h0);
    chk("idle_ready", {31'h0, CMD_READY}, 32'h1);
    m_acc = 32'h0;

    do_cmd(4'd2, 16'd5, 2'b00, 1'b0);
    do_cmd(4'd2, 16'd3, 2'b00, 1'b0);
    do_cmd(4'd4, 16'd3, 2'b00, 1'b0);

    // Overflow, then masked ovf noise on a divide, then clear-vs-report race.
    do_cmd(4'd15, 16'h0, 2'b00, 1'b0);
    do_cmd(4'd3, 16'd1, 2'b00, 1'b0);
    do_cmd(4'd5, 16'd7, 2'b01, 1'b0);
    do_cmd(4'd5, 16'd0, 2'b00, 1'b0);
    do_cmd(4'd14, 16'h0, 2'b10, 1'b0);
    do_cmd(4'd3, 16'd2, 2'b00, 1'b1);

    // Halt on divide-by-zero, fill the FIFO while halted, then resume.
    HALT_ON_ERR = 1'b1;
    do_cmd(4'd5, 16'd0, 2'b00, 1'b0);
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge CLK);
      if (idx < 5) begin
        CMD_VALID = 1'b1;
        CMD_OP    = q_op[idx];
        CMD_DATA  = q_d[idx];
        if (CMD_READY) idx++;
      end
    end
    @(negedge CLK);
    CMD_VALID = 1'b0;
    chk("halt_accepted", 32'(idx), 32'd4);
    chk("halt_full_ready", {31'h0, CMD_READY}, 32'h0);
    chk("halt_dp_op", {28'h0, DP_OP}, 32'h0);
    chk("halt_sticky", {29'h0, STICKY_ERR}, {29'h0, m_sticky});
    CLR_ERR = 1'b1;
    HALT_ON_ERR = 1'b0;
    @(negedge CLK);
    CLR_ERR = 1'b0;
    m_sticky = 3'b000;
    chk("clr_sticky", {29'h0, STICKY_ERR}, 32'h0);
    for (int i = 0; i < 4; i++) wait_result(q_op[i], q_d[i], 2'b00, 1'b0, i < 3);

    // Randomized command mix, one command in flight at a time.
    for (int i = 0; i < 40; i++) begin
      r_op = op_tab[$urandom_range(0, 11)];
      r_d  = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 2)) : 16'($urandom);
      do_cmd(r_op, r_d, 2'($urandom), $urandom_range(0, 7) == 0);
    end

    do_cmd(4'b1000, 16'h55AA, 2'b00, 1'b0);

    // Reset in the middle of a multiply's settle phase.
    @(negedge CLK);
    CMD_VALID = 1'b1; CMD_OP = 4'd4; CMD_DATA = 16'd3;
    @(negedge CLK);
    CMD_VALID = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    chk("rst2_dp_op", {28'h0, DP_OP}, 32'hF);
    chk("rst2_ready", {31'h0, CMD_READY}, 32'h0);
    chk("rst2_sticky", {29'h0, STICKY_ERR}, 32'h0);
    @(negedge CLK);
    m_acc = 32'h0;
    m_sticky = 3'b000;
    chk("rst2_busy", {31'h0, BUSY}, 32'h0);
    chk("rst2_dp_out", DP_OUT, 32'h0);
    chk("rst2_res_data", RES_DATA, 32'h0);
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      if (RES_VALID === 1'b1) seen++;
      @(negedge CLK);
    end
    chk("rst2_no_result", 32'(seen), 32'd0);
    do_cmd(4'd2, 16'd9, 2'b00, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/calc_sequencer.md
Name: calc_sequencer

Overview:
Command sequencer for the accumulator calculator datapath. It buffers {opcode, operand} commands from a host through a valid/ready FIFO and drives the datapath OP/IN one command at a time. It holds the accumulator with no-op while slow units (mul, div, mod) settle, then commits each command on a single clock edge. It reports each result with masked per-command error flags, keeps sticky error state, and can halt on error.

Parameters:
DEPTH, 4, command FIFO entries (power of 2, at least 2)
MUL_LAT, 2, no-op settle cycles before a mul commit
DIV_LAT, 1, no-op settle cycles before a div/mod commit

Ports:
CLK  in  1  clock
RST  in  1  synchronous active-high reset
CMD_VALID  in  1  host command valid
CMD_READY  out  1  FIFO not full
CMD_OP  in  4  opcode: 0000 nop, 0010 add, 0011 sub, 0100 mul, 0101 div, 0110 mod, 1110 preset, 1111 reset
CMD_DATA  in  16  operand
DP_OP  out  4  datapath opcode
DP_IN  out  16  datapath operand
DP_OUT  in  32  accumulator value
DP_ERR  in  2  datapath flags: [0] overflow, [1] divide-by-zero
RES_VALID  out  1  one-cycle result strobe
RES_DATA  out  32  accumulator value after commit
RES_ERR  out  3  [0] ovf, [1] dzero, [2] illegal opcode
STICKY_ERR  out  3  OR of all RES_ERR since last clear
CLR_ERR  in  1  clear sticky errors and leave HALT
HALT_ON_ERR  in  1  enter HALT when RES_ERR is nonzero
BUSY  out  1  state is not IDLE, or the FIFO is not empty

Behaviour:
- Reset (RST high at an edge):
  - Flush the FIFO; state becomes INIT.
  - RES_VALID=0, RES_DATA=0, RES_ERR=0, STICKY_ERR=0.
  - DP_OP=1111, DP_IN=0. CMD_READY=0 during INIT.
  - RST mid-command abandons the command with no RES_VALID.
- Handshake: push when CMD_VALID and CMD_READY are both high; CMD_READY = not full and state is not INIT. The FIFO pops only in IDLE.
- States:
  - INIT: DP_OP=1111 for exactly one cycle (clears the accumulator), then go to IDLE. No result is reported.
  - IDLE: DP_OP=0000. If the FIFO is not empty, pop into the cmd register.
    - lat=MUL_LAT for 0100; lat=DIV_LAT for 0101/0110; otherwise lat=0.
    - Go to SETTLE if lat>0, else COMMIT.
    - Illegal opcodes (0001, 0111-1101) go straight to REPORT with err=100 and are never driven on DP_OP.
  - SETTLE: DP_OP=0000, DP_IN=cmd data, for exactly lat cycles, then COMMIT.
  - COMMIT: DP_OP=cmd op, DP_IN=cmd data, for one cycle. In this cycle, capture err from DP_ERR with masking:
    - ovf counts only for 0010/0011.
    - dzero counts only for 0101/0110.
  - REPORT: RES_VALID=1, RES_DATA=DP_OUT, RES_ERR=captured err. STICKY |= err. DP_OP=0000.
    - Next state is HALT if HALT_ON_ERR and err is nonzero, else IDLE.
  - HALT: DP_OP=0000, no pops; pushes are still accepted until full. CLR_ERR moves to IDLE.
- CLR_ERR in any state zeroes STICKY. If it coincides with REPORT, STICKY = new err (new error wins).
- DP_IN holds its last value in IDLE and HALT.
- Latency: push accepted at edge N into an idle, empty block → pop at N+1 → COMMIT in cycle N+1+lat → RES_VALID in cycle N+2+lat. Throughput is one command per (3+lat) cycles.
- FIFO: full → CMD_READY=0. No push is possible while full, so push and pop never collide at full. Pointers wrap modulo DEPTH. A simultaneous push and pop at a non-full, non-empty occupancy leaves the count unchanged.

Decomposition:
- Package calc_pkg:
  - opcode localparams
  - state enum {INIT, IDLE, SETTLE, COMMIT, REPORT, HALT}
  - error bit indices
  - lat-select function
- Sub-module calc_cmd_fifo: parameterised DEPTH × 20-bit synchronous FIFO with full/empty and synchronous reset flush.

Test Plan:
1. Release RST → DP_OP=1111 for one cycle, DP_OUT=0. Push add 5, add 3 → RES_DATA 5 then 8, RES_ERR=000, STICKY=000.
2. Accumulator at 8, push mul 3 (MUL_LAT=2) → DP_OP 0000,0000 with DP_IN=3, then 0100 for one cycle. RES_DATA=24, RES_VALID asserts 4 cycles after the push edge.
3. Accumulator at 0, push sub 1 → RES_DATA=FFFFFFFF, RES_ERR=001, STICKY=001. Then push div 7 with DP_ERR[0] still high → RES_ERR=000 (ovf masked).
4. HALT_ON_ERR=1, push div 0 → RES_ERR=010, STICKY=010, enter HALT. Push 5 more commands → exactly DEPTH(4) accepted, then CMD_READY=0. Pulse CLR_ERR → STICKY=000, the queued commands execute in order.
5. Push 1000 → DP_OP never equals 1000, RES_ERR=100, RES_DATA equals the prior accumulator value.
6. Assert RST during a mul SETTLE → no RES_VALID, FIFO empty, INIT drives 1111, DP_OUT=0, BUSY=0 two cycles after release.
